// File: rtl/k_means_div_scheduler_if.sv
// Accumulator read / divider issue bus between scheduler and datapath.
// Scheduler owns reads and issue; datapath owns data, results and credits.
interface k_means_div_scheduler_if #(
  parameter int CLUSTER_BITS = 3,
  parameter int DIM_BITS     = 6
);
  logic                    acc_rd_en;
  logic [CLUSTER_BITS-1:0] acc_rd_cluster;
  logic [DIM_BITS-1:0]     acc_rd_dim;
  logic [63:0]             acc_rd_sum;
  logic [63:0]             acc_rd_count;
  logic [63:0]             div_sum;
  logic [63:0]             div_count;
  logic                    div_valid;
  logic                    div_last_dim;
  logic                    div_last;
  logic                    div_dout_valid;
  logic                    div_dout_last;
  logic                    credit_return;

  modport master (
    output acc_rd_en, acc_rd_cluster, acc_rd_dim,
    output div_sum, div_count, div_valid,
    output div_last_dim, div_last,
    input  acc_rd_sum, acc_rd_count,
    input  div_dout_valid, div_dout_last,
    input  credit_return
  );

  modport slave (
    input  acc_rd_en, acc_rd_cluster, acc_rd_dim,
    input  div_sum, div_count, div_valid,
    input  div_last_dim, div_last,
    output acc_rd_sum, acc_rd_count,
    output div_dout_valid, div_dout_last,
    output credit_return
  );
endinterface

// File: rtl/k_means_div_scheduler.sv
// Centroid division pass sequencer: walks sum/count memories cluster-major
// and issues pairs to the divider, throttled by downstream FIFO credits.
module k_means_div_scheduler #(
  parameter int CLUSTER_BITS = 3,
  parameter int DIM_BITS     = 6,
  parameter int CREDITS      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_operator,
  input  logic [CLUSTER_BITS:0] num_cluster,
  input  logic [DIM_BITS:0]     num_dim,
  input  logic                  update_start,
  k_means_div_scheduler_if.master bus,
  output logic                  busy,
  output logic                  update_done,
  output logic                  credit_err,
  output logic [31:0]           sched_debug_cnt
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [CLUSTER_BITS:0]   nc_q;
  logic [DIM_BITS:0]       nd_q;
  logic [CLUSTER_BITS-1:0] cl_q;
  logic [DIM_BITS-1:0]     dm_q;
  logic [CW-1:0]           credits_q;
  logic                    issue;
  logic                    last_dim;
  logic                    last;
  logic                    sizes_ok;

  assign sizes_ok = (num_cluster != '0) && (num_dim != '0);
  assign last_dim = {1'b0, dm_q} == nd_q - (DIM_BITS+1)'(1);
  assign last     = last_dim &&
                    ({1'b0, cl_q} == nc_q - (CLUSTER_BITS+1)'(1));

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    busy        = 1'b0;
    update_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (update_start) state_d = sizes_ok ? ISSUE : DONE;
      end
      ISSUE: begin
        busy  = 1'b1;
        issue = credits_q != '0;
        if (issue && last) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (bus.div_dout_valid && bus.div_dout_last) state_d = DONE;
      end
      DONE: begin
        update_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.acc_rd_en      = issue;
  assign bus.acc_rd_cluster = cl_q;
  assign bus.acc_rd_dim     = dm_q;
  assign bus.div_sum        = bus.acc_rd_sum;
  assign bus.div_count      = bus.acc_rd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nc_q    <= '0;
      nd_q    <= '0;
      cl_q    <= '0;
      dm_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && update_start) begin
        nc_q <= num_cluster;
        nd_q <= num_dim;
        cl_q <= '0;
        dm_q <= '0;
      end else if (issue) begin
        if (last_dim) begin
          dm_q <= '0;
          cl_q <= cl_q + 1'b1;
        end else begin
          dm_q <= dm_q + 1'b1;
        end
      end
    end
  end

  // A return that would exceed the FIFO depth means downstream lost track.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q  <= CMAX;
      credit_err <= 1'b0;
    end else begin
      case ({issue, bus.credit_return})
        2'b10: credits_q <= credits_q - CW'(1);
        2'b01: begin
          if (credits_q == CMAX) credit_err <= 1'b1;
          else credits_q <= credits_q + CW'(1);
        end
        default: credits_q <= credits_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.div_valid    <= 1'b0;
      bus.div_last_dim <= 1'b0;
      bus.div_last     <= 1'b0;
      sched_debug_cnt  <= '0;
    end else begin
      bus.div_valid    <= issue;
      bus.div_last_dim <= issue && last_dim;
      bus.div_last     <= issue && last;
      if (start_operator) sched_debug_cnt <= '0;
      else sched_debug_cnt <= sched_debug_cnt + 32'(issue);
    end
  end

endmodule
